// File: rtl/weights_loader_pkg.sv
// Shared constants and FSM encoding for the weights loader.
// Imported by the interface, the address counter and the top.
package weights_pkg;
  localparam int WEIGHTS_ADDR_W = 13;
  localparam int WEIGHTS_DATA_W = 16;
  localparam int WEIGHTS_DEPTH  = 8192;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;
endpackage

// File: rtl/weights_loader_if.sv
// Valid/ready weight-word stream into the loader.
// master: drives in_data/in_valid; slave: drives in_ready.
interface weights_loader_if
  import weights_pkg::*;
#(
  parameter int DATA_W = WEIGHTS_DATA_W
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/weights_addr_counter.sv
// Write-address / word counter with sync clear and enable.
// Ports: clk, rst, clr, en, target in; count, term out.
module weights_addr_counter
  import weights_pkg::*;
#(
  parameter int ADDR_W = WEIGHTS_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [ADDR_W:0] target,
  output logic [ADDR_W:0] count,
  output logic            term
);
  logic [ADDR_W:0] count_inc;

  assign count_inc = count + (ADDR_W+1)'(1);
  // High when the word being counted now reaches the target.
  assign term = (count_inc == target);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc;
    end
  end
endmodule

// File: rtl/weights_loader.sv
// Streams weight words into memory port A from address 0.
// Ports: clk, rst, start, load_count, stream (slave), mem_*,
// busy, done, words_written; checksum with the
// WEIGHTS_LOADER_CHECKSUM_EN macro.
module weights_loader
  import weights_pkg::*;
#(
  parameter int ADDR_W = WEIGHTS_ADDR_W,
  parameter int DATA_W = WEIGHTS_DATA_W,
  parameter int DEPTH  = WEIGHTS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_count,
  weights_loader_if.slave   stream,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              mem_select,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

  loader_state_t   state;
  logic            ready_q;
  logic [ADDR_W:0] target;
  logic [ADDR_W:0] target_in;
  logic [ADDR_W:0] count;
  logic            term;
  logic            start_ok;
  logic            accept;

  assign stream.in_ready = ready_q;
  assign start_ok  = (state == IDLE) && start;
  assign accept    = (state == LOAD) && stream.in_valid && ready_q;
  // Clamp so the address can never wrap past DEPTH-1.
  assign target_in = (load_count > MAX_CNT) ? MAX_CNT : load_count;
  assign words_written = count;

  weights_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok),
    .en     (accept),
    .target (target),
    .count  (count),
    .term   (term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      target      <= '0;
      ready_q     <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      mem_select  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            target <= target_in;
            if (target_in != '0) begin
              state      <= LOAD;
              ready_q    <= 1'b1;
              busy       <= 1'b1;
              mem_select <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            mem_address <= count[ADDR_W-1:0];
            mem_data    <= stream.in_data;
            mem_wren    <= 1'b1;
            if (term) begin
              state   <= DONE;
              ready_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        DONE: begin
          // Final write has landed; hand memory back.
          state      <= IDLE;
          mem_select <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + stream.in_data;
    end
  end
`else
  // Default build carries no running sum.
`endif
endmodule

// File: tb/tb_weights_loader.sv
// Directed, table-driven bench for weights_loader.
// Checks handshake, write stream, corners and clamping.
module tb_weights_loader;
  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] load_count;
  logic [12:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic        mem_select;
  logic        busy;
  logic        done;
  logic [13:0] words_written;
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  weights_loader_if #(.DATA_W(16)) stream ();

  weights_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .load_count    (load_count),
    .stream        (stream),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .mem_wren      (mem_wren),
    .mem_select    (mem_select),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic [13:0] lc;
    logic        valid;
    logic [15:0] din;
    logic        ready;
    logic        wren;
    logic [12:0] addr;
    logic [15:0] dout;
    logic        sel;
    logic        busy;
    logic        done;
    logic [13:0] ww;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input int r, input int s, input int lc,
                   input int vl, input int din, input int rdy,
                   input int wr, input int ad, input int dout,
                   input int sl, input int bz, input int dn,
                   input int ww);
    vec_t e;
    e.rst = 1'(r);
    e.start = 1'(s);
    e.lc = 14'(lc);
    e.valid = 1'(vl);
    e.din = 16'(din);
    e.ready = 1'(rdy);
    e.wren = 1'(wr);
    e.addr = 13'(ad);
    e.dout = 16'(dout);
    e.sel = 1'(sl);
    e.busy = 1'(bz);
    e.done = 1'(dn);
    e.ww = 14'(ww);
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int unsigned act,
                     input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic [13:0] lc, input logic vl,
                       input logic [15:0] d);
    rst = r;
    start = s;
    load_count = lc;
    stream.in_valid = vl;
    stream.in_data = d;
  endtask

  initial begin
    int writes;
    int last_addr;
    int addr_err;
    int ww_at_done;
    int wren_at_done;
    bit done_seen;

    drive(1'b1, 1'b0, 14'd0, 1'b1, 16'h0);

    // rst start lc valid din | ready wren addr dout sel busy done ww
    v(1, 0, 0, 1, 'h55,    0, 0, 0, 0,     1, 0, 0, 0);
    v(0, 1, 4, 0, 0,       1, 0, 0, 0,     0, 1, 0, 0);
    v(0, 0, 0, 1, 1,       1, 1, 0, 1,     0, 1, 0, 1);
    v(0, 0, 0, 1, 2,       1, 1, 1, 2,     0, 1, 0, 2);
    v(0, 0, 0, 1, 3,       1, 1, 2, 3,     0, 1, 0, 3);
    v(0, 0, 0, 1, 4,       0, 1, 3, 4,     0, 0, 1, 4);
    v(0, 0, 0, 0, 0,       0, 0, 3, 4,     1, 0, 0, 4);
    v(0, 1, 3, 0, 0,       1, 0, 3, 4,     0, 1, 0, 0);
    v(0, 0, 0, 1, 'h10,    1, 1, 0, 'h10,  0, 1, 0, 1);
    v(0, 0, 0, 0, 'hFFFF,  1, 0, 0, 'h10,  0, 1, 0, 1);
    v(0, 0, 0, 1, 'h20,    1, 1, 1, 'h20,  0, 1, 0, 2);
    v(0, 0, 0, 0, 0,       1, 0, 1, 'h20,  0, 1, 0, 2);
    v(0, 0, 0, 1, 'h30,    0, 1, 2, 'h30,  0, 0, 1, 3);
    v(0, 0, 0, 0, 0,       0, 0, 2, 'h30,  1, 0, 0, 3);
    v(0, 1, 0, 0, 0,       0, 0, 2, 'h30,  1, 0, 1, 0);
    v(0, 0, 0, 0, 0,       0, 0, 2, 'h30,  1, 0, 0, 0);
    v(0, 1, 5, 0, 0,       1, 0, 2, 'h30,  0, 1, 0, 0);
    v(0, 0, 0, 1, 'h100,   1, 1, 0, 'h100, 0, 1, 0, 1);
    v(0, 1, 2, 1, 'h200,   1, 1, 1, 'h200, 0, 1, 0, 2);
    v(0, 1, 5, 0, 0,       1, 0, 1, 'h200, 0, 1, 0, 2);
    v(0, 0, 0, 1, 'h300,   1, 1, 2, 'h300, 0, 1, 0, 3);
    v(0, 0, 0, 1, 'h400,   1, 1, 3, 'h400, 0, 1, 0, 4);
    v(0, 0, 0, 1, 'h500,   0, 1, 4, 'h500, 0, 0, 1, 5);
    v(0, 0, 0, 0, 0,       0, 0, 4, 'h500, 1, 0, 0, 5);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].lc,
            tbl[i].valid, tbl[i].din);
      step();
      chk($sformatf("v%0d in_ready", i), stream.in_ready, tbl[i].ready);
      chk($sformatf("v%0d mem_wren", i), mem_wren, tbl[i].wren);
      chk($sformatf("v%0d mem_address", i), mem_address, tbl[i].addr);
      chk($sformatf("v%0d mem_data", i), mem_data, tbl[i].dout);
      chk($sformatf("v%0d mem_select", i), mem_select, tbl[i].sel);
      chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d done", i), done, tbl[i].done);
      chk($sformatf("v%0d words_written", i), words_written, tbl[i].ww);
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
      if (i == 0) chk("checksum reset", checksum, 0);
      if (i == 6) chk("checksum load4", checksum, 'hA);
      if (i == 23) chk("checksum load5", checksum, 'hF00);
`endif
    end

    // Reset in the middle of a 10-word load.
    drive(1'b0, 1'b1, 14'd10, 1'b0, 16'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 14'd0, 1'b1, 16'(k + 'h40));
      step();
    end
    chk("midload ww before rst", words_written, 5);
    drive(1'b1, 1'b0, 14'd0, 1'b1, 16'h77);
    step();
    chk("rst in_ready", stream.in_ready, 0);
    chk("rst mem_select", mem_select, 1);
    chk("rst busy", busy, 0);
    chk("rst words_written", words_written, 0);
    chk("rst mem_wren", mem_wren, 0);
    drive(1'b0, 1'b1, 14'd2, 1'b0, 16'h0);
    step();
    chk("restart busy", busy, 1);
    drive(1'b0, 1'b0, 14'd0, 1'b1, 16'hAAAA);
    step();
    chk("restart addr0", mem_address, 0);
    chk("restart data0", mem_data, 'hAAAA);
    chk("restart wren0", mem_wren, 1);
    drive(1'b0, 1'b0, 14'd0, 1'b1, 16'hBBBB);
    step();
    chk("restart addr1", mem_address, 1);
    chk("restart done", done, 1);
    chk("restart ww", words_written, 2);
    drive(1'b0, 1'b0, 14'd0, 1'b0, 16'h0);
    step();

    // Over-long request clamps to DEPTH words.
    drive(1'b0, 1'b1, 14'd9000, 1'b0, 16'h0);
    step();
    chk("clamp busy", busy, 1);
    writes = 0;
    last_addr = -1;
    addr_err = 0;
    ww_at_done = 0;
    wren_at_done = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 8300 && !done_seen; k++) begin
      drive(1'b0, 1'b0, 14'd0, 1'b1, 16'(k));
      step();
      if (mem_wren) begin
        if (int'(mem_address) != writes) addr_err++;
        writes++;
        last_addr = int'(mem_address);
      end
      if (done) begin
        done_seen = 1'b1;
        ww_at_done = int'(words_written);
        wren_at_done = int'(mem_wren);
      end
    end
    chk("clamp done seen", done_seen, 1);
    chk("clamp writes", writes, 8192);
    chk("clamp last address", last_addr, 'h1FFF);
    chk("clamp address order errs", addr_err, 0);
    chk("clamp ww at done", ww_at_done, 8192);
    chk("clamp wren with done", wren_at_done, 1);
    chk("clamp in_ready after", stream.in_ready, 0);
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    chk("clamp checksum", checksum, 'hF000);
`endif
    drive(1'b0, 1'b0, 14'd0, 1'b1, 16'h0);
    step();
    chk("clamp select back", mem_select, 1);
    chk("clamp no extra write", mem_wren, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
